// File: rtl/stop_it_sequencer.sv
// Stop-It game control: paces shift pulses, judges the stop press and tracks the level.
// Optional build macro STOP_IT_AUTO_RESTART_EN: WIN/LOSE time out after a result hold.
//
// Ports:
//   clk_i, rst_i      clock and synchronous active-high reset
//   start_i, stop_i   single-cycle button pulses
//   leds_i            LED bus read back from the shifter
//   shift_o, load_o   one-cycle requests to the shifter
//   off_o             level-sensitive clear request to the shifter
//   win_o, lose_o     result indicators
//   level_o           current speed level
//   running_o         high while the LEDs are moving
module stop_it_sequencer #(
  parameter int TICK_CYCLES  = 25_000_000,
  parameter int LEVELS       = 4,
  parameter int GRACE_SHIFTS = 1,
  parameter int RESULT_TICKS = 4,
  localparam int LW = (LEVELS > 1) ? $clog2(LEVELS) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          stop_i,
  input  logic [15:0]   leds_i,
  output logic          shift_o,
  output logic          load_o,
  output logic          off_o,
  output logic          win_o,
  output logic          lose_o,
  output logic [LW-1:0] level_o,
  output logic          running_o
);

  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int GW = (GRACE_SHIFTS > 0) ? $clog2(GRACE_SHIFTS + 1) : 1;
  localparam int HOLD = RESULT_TICKS * TICK_CYCLES;

  generate
    if (TICK_CYCLES < (1 << (LEVELS - 1))) begin : g_bad_tick
      $error("TICK_CYCLES too small for LEVELS");
    end
    if (HOLD < 1) begin : g_bad_hold
      $error("RESULT_TICKS*TICK_CYCLES must be positive");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_WIN,
    S_LOSE
  } state_e;

  state_e        state_q, state_d;
  logic [LW-1:0] level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] grace_q, grace_d;
  logic [CW-1:0] p_last;
  logic [GW-1:0] grace_inc;
  logic          full;
  logic          shift;
  logic          hold_done;

`ifdef STOP_IT_AUTO_RESTART_EN
  localparam int RW = (HOLD > 1) ? $clog2(HOLD) : 1;
  logic [RW-1:0] res_q, res_d;
  assign hold_done = (res_q == RW'(HOLD - 1));
`else
  assign hold_done = 1'b0;
`endif

  assign full      = (leds_i == 16'hFFFF);
  assign grace_inc = grace_q + GW'(1);

  // Last count of the current period; period halves per level.
  always_comb begin
    p_last = CW'((TICK_CYCLES >> level_q) - 1);
  end

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    grace_d = grace_q;
    shift   = 1'b0;
`ifdef STOP_IT_AUTO_RESTART_EN
    res_d   = res_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_LOAD;
      end
      S_LOAD: begin
        state_d = S_RUN;
        cnt_d   = '0;
        grace_d = '0;
      end
      S_RUN: begin
        // Stop is judged on the pre-shift LEDs and pre-empts a shift.
        if (stop_i) begin
          if (full) begin
            state_d = S_WIN;
            if (level_q != LW'(LEVELS - 1)) level_d = level_q + LW'(1);
          end else begin
            state_d = S_LOSE;
            level_d = '0;
          end
        end else if (cnt_q == p_last) begin
          shift = 1'b1;
          cnt_d = '0;
          if (full) begin
            grace_d = grace_inc;
            if (grace_inc >= GW'(GRACE_SHIFTS)) begin
              state_d = S_LOSE;
              level_d = '0;
            end
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`ifdef STOP_IT_AUTO_RESTART_EN
        res_d = '0;
`endif
      end
      S_WIN: begin
        if (start_i || hold_done) state_d = S_LOAD;
`ifdef STOP_IT_AUTO_RESTART_EN
        res_d = res_q + RW'(1);
`endif
      end
      S_LOSE: begin
        if (start_i || hold_done) state_d = S_IDLE;
`ifdef STOP_IT_AUTO_RESTART_EN
        res_d = res_q + RW'(1);
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      level_q <= '0;
      cnt_q   <= '0;
      grace_q <= '0;
`ifdef STOP_IT_AUTO_RESTART_EN
      res_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      grace_q <= grace_d;
`ifdef STOP_IT_AUTO_RESTART_EN
      res_q   <= res_d;
`endif
    end
  end

  // Pulses are masked during reset so nothing reaches the shifter.
  assign shift_o   = shift && !rst_i;
  assign load_o    = (state_q == S_LOAD) && !rst_i;
  assign off_o     = (state_q == S_IDLE);
  assign running_o = (state_q == S_RUN);
  assign win_o     = (state_q == S_WIN);
  assign lose_o    = (state_q == S_LOSE);
  assign level_o   = level_q;

endmodule

// File: tb/tb_stop_it_sequencer.sv
// Scoreboard bench for stop_it_sequencer with a simple LED shifter model.
// Expected shifter events are queued by the stimulus and matched by a monitor.
module tb_stop_it_sequencer;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        stop_i = 1'b0;
  logic [15:0] leds = 16'h0000;
  logic [15:0] sw = 16'h0000;
  logic        shift_o, load_o, off_o, win_o, lose_o, running_o;
  logic [1:0]  level_o;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int kind;
    int cyc;
    int lvl;
  } ev_t;

  ev_t exp_q[$];

  localparam int K_LOAD  = 0;
  localparam int K_SHIFT = 1;
  localparam int K_WIN   = 2;
  localparam int K_LOSE  = 3;

  stop_it_sequencer #(
    .TICK_CYCLES(8),
    .LEVELS(4),
    .GRACE_SHIFTS(1),
    .RESULT_TICKS(4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .start_i(start_i),
    .stop_i(stop_i),
    .leds_i(leds),
    .shift_o(shift_o),
    .load_o(load_o),
    .off_o(off_o),
    .win_o(win_o),
    .lose_o(lose_o),
    .level_o(level_o),
    .running_o(running_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Shifter model: clear, load switches, or shift a one in from the right.
  always @(posedge clk) begin
    if (off_o === 1'b1) leds <= 16'h0000;
    else if (load_o === 1'b1) leds <= sw;
    else if (shift_o === 1'b1) leds <= {leds[14:0], 1'b1};
  end

  function automatic void chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void push(int k, int c, int l);
    ev_t e;
    e.kind = k;
    e.cyc = c;
    e.lvl = l;
    exp_q.push_back(e);
  endfunction

  function automatic void observe(int k);
    ev_t e;
    n_chk++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind=%0d cyc=%0d lvl=%0d, none expected",
               k, cyc, level_o);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.cyc != cyc || e.lvl != int'(level_o)) begin
        n_fail++;
        $display("FAIL event: got kind=%0d cyc=%0d lvl=%0d expected kind=%0d cyc=%0d lvl=%0d",
                 k, cyc, level_o, e.kind, e.cyc, e.lvl);
      end
    end
  endfunction

  logic win_p = 1'b0;
  logic lose_p = 1'b0;

  always @(negedge clk) begin
    if (load_o === 1'b1) observe(K_LOAD);
    if (shift_o === 1'b1) observe(K_SHIFT);
    if (win_o === 1'b1 && !win_p) observe(K_WIN);
    if (lose_o === 1'b1 && !lose_p) observe(K_LOSE);
    win_p = (win_o === 1'b1);
    lose_p = (lose_o === 1'b1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(int t);
    while (cyc < t) step();
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  task automatic pulse_stop();
    stop_i = 1'b1;
    step();
    stop_i = 1'b0;
  endtask

  int c;

  initial begin
    rst_i = 1'b1;
    step();
    step();
    chk("rst_off", off_o, 1);
    chk("rst_shift", shift_o, 0);
    chk("rst_load", load_o, 0);
    chk("rst_level", level_o, 0);
    chk("rst_win", win_o, 0);
    chk("rst_lose", lose_o, 0);
    chk("rst_running", running_o, 0);
    rst_i = 1'b0;
    step();

    // Level 0 run to full, stop before the next shift: win.
    c = cyc;
    sw = 16'h3FFF;
    push(K_LOAD, c + 1, 0);
    push(K_SHIFT, c + 9, 0);
    push(K_SHIFT, c + 17, 0);
    push(K_WIN, c + 21, 1);
    pulse_start();
    wait_to(c + 2);
    chk("run_running", running_o, 1);
    chk("run_no_load_off", load_o | off_o, 0);
    wait_to(c + 20);
    pulse_stop();
    wait_to(c + 22);
    chk("win_hold", win_o, 1);
    chk("win_level", level_o, 1);
    chk("win_no_off", off_o, 0);

    // Level 1, period 4; stop coincides with a shift on full LEDs.
    c = cyc;
    sw = 16'h3FFF;
    push(K_LOAD, c + 1, 1);
    push(K_SHIFT, c + 5, 1);
    push(K_SHIFT, c + 9, 1);
    push(K_WIN, c + 14, 2);
    pulse_start();
    wait_to(c + 13);
    pulse_stop();
    wait_to(c + 15);
    chk("coinc_win", win_o, 1);
    chk("coinc_level", level_o, 2);

    // Level 2, period 2; reset lands on a shift cycle.
    c = cyc;
    sw = 16'h00FF;
    push(K_LOAD, c + 1, 2);
    push(K_SHIFT, c + 3, 2);
    push(K_SHIFT, c + 5, 2);
    pulse_start();
    wait_to(c + 7);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("mrst_off", off_o, 1);
    chk("mrst_level", level_o, 0);
    chk("mrst_shift", shift_o, 0);
    chk("mrst_running", running_o, 0);

    // Early loss with partially lit LEDs.
    c = cyc;
    sw = 16'h00FF;
    push(K_LOAD, c + 1, 0);
    push(K_LOSE, c + 5, 0);
    pulse_start();
    wait_to(c + 4);
    pulse_stop();
    wait_to(c + 6);
    chk("early_lose", lose_o, 1);
    chk("early_level", level_o, 0);
    chk("early_no_off", off_o, 0);

    // Start from LOSE clears to IDLE first.
    pulse_start();
    chk("lose_to_idle_off", off_o, 1);
    chk("lose_to_idle_load", load_o, 0);
    chk("lose_to_idle_lose", lose_o, 0);

    // Late loss: full LEDs, no stop, lose on the next shift.
    c = cyc;
    sw = 16'h7FFF;
    push(K_LOAD, c + 1, 0);
    push(K_SHIFT, c + 9, 0);
    push(K_SHIFT, c + 17, 0);
    push(K_LOSE, c + 18, 0);
    pulse_start();
    wait_to(c + 19);
    chk("late_lose", lose_o, 1);

    // Start and stop together while running: stop wins.
    pulse_start();
    c = cyc;
    sw = 16'h00FF;
    push(K_LOAD, c + 1, 0);
    push(K_LOSE, c + 5, 0);
    pulse_start();
    wait_to(c + 4);
    start_i = 1'b1;
    stop_i = 1'b1;
    step();
    start_i = 1'b0;
    stop_i = 1'b0;
    wait_to(c + 6);
    chk("both_lose", lose_o, 1);
    chk("both_running", running_o, 0);

    wait_to(cyc + 20);
    chk("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
